// File: rtl/uart_rx_sampler.sv
// UART receive front-end: synchronises rx_in, strobes each data bit sampled mid-bit (LSB first), flags stop status.
// Outputs registered, one bit period per data strobe; no backpressure: consumer must take every one-cycle strobe.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_in,
    output logic bit_out,
    output logic bit_valid,
    output logic frame_done,
    output logic frame_error,
    output logic busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state, state_nx;
    logic [1:0]    sync_q;
    logic          rx_s;
    logic [CW-1:0] cnt, cnt_nx;
    logic [IW-1:0] idx, idx_nx;
    logic          bit_nx, valid_nx, done_nx, err_nx, busy_nx;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= 2'b11;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], rx_in};
            state       <= state_nx;
            cnt         <= cnt_nx;
            idx         <= idx_nx;
            bit_out     <= bit_nx;
            bit_valid   <= valid_nx;
            frame_done  <= done_nx;
            frame_error <= err_nx;
            busy        <= busy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        bit_nx   = bit_out;
        valid_nx = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                idx_nx = '0;
                if (!rx_s) state_nx = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx   = '0;
                    // A start bit that is gone by mid-bit was only a glitch
                    state_nx = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx   = '0;
                    bit_nx   = rx_s;
                    valid_nx = 1'b1;
                    if (idx == IDX_LAST) begin
                        idx_nx   = '0;
                        state_nx = STOP;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx = '0;
                    if (rx_s) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = WAIT_HIGH;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WAIT_HIGH: begin
                // A held-low break line must not re-trigger start detection
                cnt_nx = '0;
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end
endmodule
